occ_mem_arbiter: RTL and testbench
==================================

OCC_MEM_ARBITER -- requirements
Module: occ_mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of requesting channels (2..8).
REQ-002 Parameter ADDR_W, default 8: memory address width.
REQ-003 Parameter DATA_W, default 32: memory data width.
REQ-004 Parameter TIMEOUT, default 15: maximum FETCH cycles to wait for mem_valid_i (1..255).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_i  input  NUM_CH  per-channel request; held high with addr until gnt_o for that channel.
REQ-008 addr_i  input  NUM_CH*ADDR_W  per-channel address; channel k occupies bits [k*ADDR_W +: ADDR_W].
REQ-009 gnt_o  output  NUM_CH  one-hot, one-cycle accept pulse.
REQ-010 rsp_valid_o  output  NUM_CH  one-hot, one-cycle response pulse.
REQ-011 rsp_data_o  output  DATA_W  shared response data; valid with rsp_valid_o, held until the next capture.
REQ-012 rsp_err_o  output  1  high with rsp_valid_o when the fetch timed out.
REQ-013 mem_ce_o / mem_addr_o  output  1 / ADDR_W  memory enable and address.
REQ-014 mem_data_i / mem_valid_i  input  DATA_W / 1  memory data and its valid qualifier.
REQ-015 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states: IDLE, FETCH, RESP; all outputs are registered.
REQ-017 IDLE: with any req_i high at a clock edge, select the first requesting channel in round-robin order starting at (last_granted+1) mod NUM_CH; pulse gnt_o for it, latch its address, and enter FETCH.
REQ-018 last_granted resets to NUM_CH-1, so channel 0 has first priority after reset.
REQ-019 FETCH: mem_ce_o=1 and mem_addr_o=latched address for every cycle in FETCH; mem_ce_o=0 in all other states.
REQ-020 FETCH: mem_valid_i high at an edge captures mem_data_i into rsp_data_o, clears the error flag, and enters RESP.
REQ-021 FETCH: a cycle counter increments each FETCH cycle; on reaching TIMEOUT without valid, enter RESP with rsp_err_o=1 and rsp_data_o unchanged.
REQ-022 RESP: rsp_valid_o pulses for exactly one cycle on the granted channel, then return to IDLE; requests are not sampled in RESP.
REQ-023 Latency with zero-wait memory: req_i sampled at edge 0 -> gnt_o in cycle 1 -> rsp_valid_o in cycle 2; minimum request-to-request spacing is 3 cycles.
REQ-024 Only one transaction is outstanding; requests arriving while busy wait in round-robin order.
REQ-025 A channel dropping req_i before its grant is simply not selected; no error results.
REQ-026 mem_valid_i outside FETCH is ignored.

Reset
REQ-027 rst_n low asynchronously forces IDLE, and clears gnt_o, rsp_valid_o, rsp_err_o, mem_ce_o, busy_o, rsp_data_o, mem_addr_o and the counter to 0.
REQ-028 Reset mid-FETCH abandons the transaction; no rsp_valid_o is issued for it.

Configuration
REQ-029 Macro OCC_ARB_CACHE_EN, when defined, adds a one-entry result cache of {valid, address, data}.
REQ-030 The cache is filled on every non-error capture and invalidated by reset.
REQ-031 With the macro: in IDLE, a selected address that equals a valid cache address pulses gnt_o and enters RESP directly with the cached data; mem_ce_o stays 0 and latency is one cycle shorter.
REQ-032 Without the macro: there is no cache logic and every grant goes through FETCH.

Verification
REQ-033 Single request: ch2 req, addr 0x15, memory returns 0xDEADBEEF with zero wait -> gnt_o=0100 in cycle 1, rsp_valid_o=0100 with data 0xDEADBEEF in cycle 2.
REQ-034 Round-robin: all four channels requesting continuously from reset -> grant order 0,1,2,3,0.
REQ-035 Timeout: TIMEOUT=15, mem_valid_i held 0 -> RESP after 15 FETCH cycles with rsp_err_o=1, and rsp_data_o holds the previous value.
REQ-036 Wait states: mem_valid_i asserted 3 cycles into FETCH -> mem_ce_o high for 3 cycles, correct data returned, rsp_err_o=0.
REQ-037 Reset mid-FETCH: rst_n pulsed low -> outputs go to 0 immediately, no rsp_valid_o follows, and the next grant goes to ch0.
REQ-038 Cache (OCC_ARB_CACHE_EN): ch1 reads 0x20, then ch3 reads 0x20 -> second response arrives with no mem_ce_o assertion, one cycle sooner, with the same data.

Source files
------------

// File: rtl/occ_mem_arbiter.sv
// -----------------------------------------------------------------------------
// occ_mem_arbiter
//
// Round-robin arbiter that lets NUM_CH channels share one memory read port.
// There is only ever one transaction in flight. The FSM walks IDLE -> FETCH
// -> RESP. An optional one-entry result cache, enabled with the macro
// OCC_ARB_CACHE_EN, answers a repeated address straight from IDLE. Without
// that macro every grant goes through FETCH.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   req_i        : per-channel request, held with its address until granted
//   addr_i       : per-channel address, channel k at [k*ADDR_W +: ADDR_W]
//   gnt_o        : one-hot, one-cycle accept pulse
//   rsp_valid_o  : one-hot, one-cycle response pulse on the granted channel
//   rsp_data_o   : shared response data, held until the next capture
//   rsp_err_o    : high with rsp_valid_o when the fetch timed out
//   mem_ce_o     : memory enable, high for every FETCH cycle
//   mem_addr_o   : latched address of the current transaction
//   mem_data_i   : memory read data
//   mem_valid_i  : qualifies mem_data_i, only observed in FETCH
//   busy_o       : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module occ_mem_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH*ADDR_W-1:0] addr_i,
    output logic [NUM_CH-1:0]        gnt_o,
    output logic [NUM_CH-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]        rsp_data_o,
    output logic                     rsp_err_o,
    output logic                     mem_ce_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic [DATA_W-1:0]        mem_data_i,
    input  logic                     mem_valid_i,
    output logic                     busy_o
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_last;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_found;
    logic [CH_W-1:0]     w_sel;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_timeout;
    logic                w_hit;
    logic [DATA_W-1:0]   w_cache_data;

    logic                w_grant;
    logic [NUM_CH-1:0]   w_gnt_nxt;
    logic [NUM_CH-1:0]   w_rsp_vld_nxt;
    logic                w_err_nxt;
    logic                w_data_ld;
    logic [DATA_W-1:0]   w_data_nxt;

    // Channel index 'off' positions after the last granted channel.
    // last+1+off never exceeds 2*NUM_CH-1, so one subtraction is a full modulo.
    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] last, input int off);
        int t;
        t = int'(last) + 1 + off;
        if (t >= NUM_CH) t = t - NUM_CH;
        return t[CH_W-1:0];
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: first requester at or after last_granted+1.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && req_i[rr_idx(r_last, i)]) begin
                w_found = 1'b1;
                w_sel   = rr_idx(r_last, i);
            end
        end
    end

    assign w_sel_addr = addr_i[int'(w_sel)*ADDR_W +: ADDR_W];
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

`ifdef OCC_ARB_CACHE_EN
    logic              r_cache_vld;
    logic [ADDR_W-1:0] r_cache_addr;
    logic [DATA_W-1:0] r_cache_data;

    // Every successful capture refreshes the single entry; a timed-out
    // fetch carries no data, so it never fills the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_vld  <= 1'b0;
            r_cache_addr <= '0;
            r_cache_data <= '0;
        end else if (r_state == S_FETCH && mem_valid_i) begin
            r_cache_vld  <= 1'b1;
            r_cache_addr <= mem_addr_o;
            r_cache_data <= mem_data_i;
        end
    end

    assign w_hit        = r_cache_vld && (w_sel_addr == r_cache_addr);
    assign w_cache_data = r_cache_data;
`else
    assign w_hit        = 1'b0;
    assign w_cache_data = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = w_hit ? S_RESP : S_FETCH;
            S_FETCH: if (mem_valid_i || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    // A valid on the last allowed cycle wins over the timeout.
    always_comb begin
        w_grant       = 1'b0;
        w_gnt_nxt     = '0;
        w_rsp_vld_nxt = '0;
        w_err_nxt     = 1'b0;
        w_data_ld     = 1'b0;
        w_data_nxt    = mem_data_i;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant   = 1'b1;
                    w_gnt_nxt = onehot(w_sel);
                    if (w_hit) begin
                        w_rsp_vld_nxt = onehot(w_sel);
                        w_data_ld     = 1'b1;
                        w_data_nxt    = w_cache_data;
                    end
                end
            end
            S_FETCH: begin
                if (mem_valid_i) begin
                    w_rsp_vld_nxt = onehot(r_last);
                    w_data_ld     = 1'b1;
                end else if (w_timeout) begin
                    w_rsp_vld_nxt = onehot(r_last);
                    w_err_nxt     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_o       <= '0;
            rsp_valid_o <= '0;
            rsp_err_o   <= 1'b0;
            rsp_data_o  <= '0;
            mem_ce_o    <= 1'b0;
            mem_addr_o  <= '0;
            busy_o      <= 1'b0;
            r_cnt       <= '0;
            r_last      <= CH_W'(NUM_CH - 1);
        end else begin
            gnt_o       <= w_gnt_nxt;
            rsp_valid_o <= w_rsp_vld_nxt;
            rsp_err_o   <= w_err_nxt;
            mem_ce_o    <= (w_state_nxt == S_FETCH);
            busy_o      <= (w_state_nxt != S_IDLE);
            if (w_data_ld) rsp_data_o <= w_data_nxt;
            if (w_grant) begin
                r_last     <= w_sel;
                mem_addr_o <= w_sel_addr;
                r_cnt      <= '0;
            end else if (r_state == S_FETCH) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_occ_mem_arbiter.sv
module tb_occ_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_i;
    logic [31:0] addr_i;
    logic [3:0]  gnt_o;
    logic [3:0]  rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        mem_ce_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_data_i;
    logic        mem_valid_i;
    logic        busy_o;

    int total;
    int bad;

    // Simple memory: answers after mem_wait extra FETCH cycles when enabled.
    logic        mem_en;
    int          mem_wait;
    logic [31:0] mem_rdata;
    int          fetch_cyc;

    occ_mem_arbiter #(
        .NUM_CH(4), .ADDR_W(8), .DATA_W(32), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o), .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o),
        .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_ce_o) fetch_cyc <= 0;
        else           fetch_cyc <= fetch_cyc + 1;
    end

    assign mem_valid_i = mem_en && mem_ce_o && (fetch_cyc == mem_wait);
    assign mem_data_i  = mem_rdata;

    task automatic test_reset();
        rst_n = 1'b0; req_i = '0; addr_i = '0;
        mem_en = 1'b1; mem_wait = 0; mem_rdata = '0;
        @(negedge clk);
        total++; if (gnt_o !== 4'b0) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt_o); end
        total++; if (rsp_valid_o !== 4'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid_o); end
        total++; if (rsp_data_o !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", rsp_data_o); end
        total++; if ({rsp_err_o, mem_ce_o, busy_o} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {rsp_err_o, mem_ce_o, busy_o}); end
        total++; if (mem_addr_o !== 8'h0) begin bad++; $display("FAIL reset_addr: got %h want 00", mem_addr_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        req_i = 4'b0100; addr_i = 32'h0015_0000;
        mem_en = 1'b1; mem_wait = 0; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (gnt_o !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", gnt_o); end
        total++; if (mem_ce_o !== 1'b1 || mem_addr_o !== 8'h15) begin bad++; $display("FAIL single_mem: got ce=%b addr=%h want ce=1 addr=15", mem_ce_o, mem_addr_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy_o); end
        req_i = '0;
        @(negedge clk);
        total++; if (rsp_valid_o !== 4'b0100) begin bad++; $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid_o); end
        total++; if (rsp_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", rsp_data_o); end
        total++; if (rsp_err_o !== 1'b0 || gnt_o !== 4'b0 || mem_ce_o !== 1'b0) begin bad++; $display("FAIL single_resp_side: got err=%b gnt=%b ce=%b want 0/0000/0", rsp_err_o, gnt_o, mem_ce_o); end
        @(negedge clk);
        total++; if (rsp_valid_o !== 4'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL single_done: got rv=%b busy=%b want 0000/0", rsp_valid_o, busy_o); end
    endtask

    task automatic test_round_robin();
        logic [3:0] got [5];
        int         gcyc [5];
        logic [3:0] exp [5];
        int n;
        int cyc;
        exp[0] = 4'b0001; exp[1] = 4'b0010; exp[2] = 4'b0100; exp[3] = 4'b1000; exp[4] = 4'b0001;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_i = 4'b1111; addr_i = 32'h0403_0201;
        mem_en = 1'b1; mem_wait = 0; mem_rdata = 32'h1234_5678;
        n = 0; cyc = 0;
        while (n < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (gnt_o != 4'b0) begin got[n] = gnt_o; gcyc[n] = cyc; n++; end
        end
        req_i = '0;
        total++; if (n != 5) begin bad++; $display("FAIL rr_count: got %0d grants want 5", n); end
        for (int k = 0; k < n; k++) begin
            total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL rr_order%0d: got %b want %b", k, got[k], exp[k]); end
        end
        if (n >= 2) begin
            total++; if (gcyc[1] - gcyc[0] != 3) begin bad++; $display("FAIL rr_spacing: got %0d want 3", gcyc[1] - gcyc[0]); end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_timeout();
        int ce_cnt;
        int cyc;
        logic seen;
        logic [3:0] rv;
        logic err;
        logic [31:0] dat;
        req_i = 4'b0010; addr_i = 32'h0000_3300;
        mem_en = 1'b1; mem_wait = 0; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        req_i = '0;
        repeat (2) @(negedge clk);
        total++; if (rsp_data_o !== 32'hCAFEF00D) begin bad++; $display("FAIL tmo_prime: got %h want cafef00d", rsp_data_o); end
        mem_en = 1'b0; mem_rdata = 32'h5555_5555;
        req_i = 4'b0010; addr_i = 32'h0000_4400;
        ce_cnt = 0; cyc = 0; seen = 1'b0; rv = '0; err = 1'b0; dat = '0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (gnt_o[1]) req_i = '0;
            if (mem_ce_o) ce_cnt++;
            if (rsp_valid_o != 4'b0) begin seen = 1'b1; rv = rsp_valid_o; err = rsp_err_o; dat = rsp_data_o; end
        end
        total++; if (!seen) begin bad++; $display("FAIL tmo_resp: got no response want one within 40 cycles"); end
        total++; if (ce_cnt != 15) begin bad++; $display("FAIL tmo_ce_cycles: got %0d want 15", ce_cnt); end
        total++; if (rv !== 4'b0010 || err !== 1'b1) begin bad++; $display("FAIL tmo_err: got rv=%b err=%b want 0010/1", rv, err); end
        total++; if (dat !== 32'hCAFEF00D) begin bad++; $display("FAIL tmo_data: got %h want cafef00d", dat); end
        @(negedge clk);
        total++; if (rsp_err_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL tmo_after: got err=%b busy=%b want 0/0", rsp_err_o, busy_o); end
        mem_en = 1'b1;
    endtask

    task automatic test_wait_states();
        int ce_cnt;
        int cyc;
        logic seen;
        logic [3:0] rv;
        logic err;
        logic [31:0] dat;
        mem_en = 1'b1; mem_wait = 2; mem_rdata = 32'h0BADCAFE;
        req_i = 4'b1000; addr_i = 32'h7700_0000;
        ce_cnt = 0; cyc = 0; seen = 1'b0; rv = '0; err = 1'b1; dat = '0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (gnt_o[3]) req_i = '0;
            if (mem_ce_o) begin
                ce_cnt++;
                total++; if (mem_addr_o !== 8'h77) begin bad++; $display("FAIL ws_addr: got %h want 77", mem_addr_o); end
            end
            if (rsp_valid_o != 4'b0) begin seen = 1'b1; rv = rsp_valid_o; err = rsp_err_o; dat = rsp_data_o; end
        end
        total++; if (ce_cnt != 3) begin bad++; $display("FAIL ws_ce_cycles: got %0d want 3", ce_cnt); end
        total++; if (rv !== 4'b1000 || err !== 1'b0) begin bad++; $display("FAIL ws_rsp: got rv=%b err=%b want 1000/0", rv, err); end
        total++; if (dat !== 32'h0BADCAFE) begin bad++; $display("FAIL ws_data: got %h want 0badcafe", dat); end
        mem_wait = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fetch();
        logic saw;
        mem_en = 1'b0;
        req_i = 4'b0100; addr_i = 32'h0010_0000;
        @(negedge clk);
        total++; if (gnt_o !== 4'b0100) begin bad++; $display("FAIL rmf_gnt: got %b want 0100", gnt_o); end
        req_i = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({mem_ce_o, busy_o, rsp_err_o} !== 3'b000 || gnt_o !== 4'b0 || rsp_valid_o !== 4'b0) begin bad++; $display("FAIL rmf_flags: got ce=%b busy=%b err=%b gnt=%b rv=%b want all 0", mem_ce_o, busy_o, rsp_err_o, gnt_o, rsp_valid_o); end
        total++; if (rsp_data_o !== 32'h0 || mem_addr_o !== 8'h0) begin bad++; $display("FAIL rmf_clear: got data=%h addr=%h want 0/0", rsp_data_o, mem_addr_o); end
        #1 rst_n = 1'b1;
        mem_en = 1'b1;
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid_o != 4'b0) saw = 1'b1;
        end
        total++; if (saw !== 1'b0) begin bad++; $display("FAIL rmf_no_rsp: got a response want none"); end
        req_i = 4'b1111; addr_i = 32'h0807_0605;
        @(negedge clk);
        total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL rmf_next_gnt: got %b want 0001", gnt_o); end
        req_i = '0;
        repeat (3) @(negedge clk);
    endtask

`ifdef OCC_ARB_CACHE_EN
    task automatic test_cache();
        req_i = 4'b0010; addr_i = 32'h0000_2000;
        mem_en = 1'b1; mem_wait = 0; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        req_i = '0;
        repeat (2) @(negedge clk);
        mem_rdata = 32'h9999_9999;
        req_i = 4'b1000; addr_i = 32'h2000_0000;
        @(negedge clk);
        total++; if (gnt_o !== 4'b1000 || rsp_valid_o !== 4'b1000) begin bad++; $display("FAIL cache_hit: got gnt=%b rv=%b want 1000/1000", gnt_o, rsp_valid_o); end
        total++; if (rsp_data_o !== 32'h1111_2222 || mem_ce_o !== 1'b0) begin bad++; $display("FAIL cache_data: got data=%h ce=%b want 11112222/0", rsp_data_o, mem_ce_o); end
        req_i = '0;
        @(negedge clk);
        total++; if (rsp_valid_o !== 4'b0 || mem_ce_o !== 1'b0) begin bad++; $display("FAIL cache_after: got rv=%b ce=%b want 0000/0", rsp_valid_o, mem_ce_o); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_wait_states();
        test_reset_mid_fetch();
`ifdef OCC_ARB_CACHE_EN
        test_cache();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
